// File: rtl/pipe_latch_pkg.sv
// Shared pipeline constants: datapath widths, control-field encodings and
// the default payload/control widths used by inter-stage latches.
package pipe_latch_pkg;

    // Architectural widths of one pipeline stage
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 8;

    // Control-field encodings that a bubble must carry
    localparam logic CTRL_REG_WRITE_DIS  = 1'b0;
    localparam logic CTRL_MEM_TO_REG_ALU = 1'b0;
    localparam logic CTRL_IS_JAL_OFF     = 1'b0;

    // Control bundle carried alongside the payload
    typedef struct packed {
        logic is_jal;
        logic mem_to_reg;
        logic reg_write;
    } stage_ctrl_t;

    // Payload: ALU result, read data, PC+4 and destination register
    localparam int PAYLOAD_W     = 3 * DATA_WIDTH + REG_ADDR_WIDTH;
    localparam int CTRL_FIELDS_W = $bits(stage_ctrl_t);

    // A bubble never writes the register file and selects the ALU path
    localparam stage_ctrl_t BUBBLE_CTRL = '{
        is_jal:     CTRL_IS_JAL_OFF,
        mem_to_reg: CTRL_MEM_TO_REG_ALU,
        reg_write:  CTRL_REG_WRITE_DIS
    };
    localparam logic [CTRL_FIELDS_W-1:0] BUBBLE_CTRL_BITS = BUBBLE_CTRL;

    // Pointer width for a ring of the given depth (at least one bit)
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_latch_mem.sv
// Entry storage for the pipeline latch: a small register array with one
// synchronous write port and one asynchronous read port. Not reset.
module pipe_latch_mem #(
    parameter int DEPTH  = 2,
    parameter int WIDTH  = 107,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the accepted entry into its slot; contents are never cleared
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_latch.sv
// Elastic pipeline latch: a DEPTH-entry FIFO between two pipeline stages
// with valid/ready handshakes, synchronous flush and bubble insertion.
// Handshake readiness comes from registered occupancy only, so there is no
// combinational path from out_ready to in_ready.
module pipe_latch
    import pipe_latch_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_W,
    parameter int CTRL_W = CTRL_FIELDS_W,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W   = ptr_width(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + CTRL_W;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CTRL_W-1:0] BUBBLE     = CTRL_W'(BUBBLE_CTRL_BITS);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Advance a ring pointer, wrapping after the last slot
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake status straight from the occupancy register
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);

    // A flush cancels both handshakes in the cycle it is seen; a push while
    // full is refused even if a pop frees a slot in the same cycle
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset empties the latch without a clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry = {in_data, in_ctrl};

    pipe_latch_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENTRY_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Bubble mux: stale storage never leaks out while the latch is empty
    always_comb begin
        out_data = '0;
        out_ctrl = BUBBLE;
        if (out_valid) begin
            out_data = rd_entry[ENTRY_W-1:CTRL_W];
            out_ctrl = rd_entry[CTRL_W-1:0];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_latch.sv
// Bench for pipe_latch: a queue-based reference model per instance checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_pipe_latch;

    localparam int DW = 104;
    localparam int CW = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // DEPTH=2 instance
    logic          flush2 = 1'b0, iv2 = 1'b0, or2 = 1'b0;
    logic [DW-1:0] id2 = '0;
    logic [CW-1:0] ic2 = '0;
    logic          ir2, ov2;
    logic [DW-1:0] od2;
    logic [CW-1:0] oc2;
    logic [1:0]    cnt2;

    // DEPTH=4 instance
    logic          flush4 = 1'b0, iv4 = 1'b0, or4 = 1'b0;
    logic [DW-1:0] id4 = '0;
    logic [CW-1:0] ic4 = '0;
    logic          ir4, ov4;
    logic [DW-1:0] od4;
    logic [CW-1:0] oc4;
    logic [2:0]    cnt4;

    int vectors = 0;
    int miscompares = 0;

    ent_t m2[$];
    ent_t m4[$];
    logic [DW-1:0] pops4[$];

    always #5 clk = ~clk;

    pipe_latch #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2)) u2 (
        .clk(clk), .reset(rst_n), .flush(flush2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_ctrl(ic2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ctrl(oc2),
        .count(cnt2)
    );

    pipe_latch #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(4)) u4 (
        .clk(clk), .reset(rst_n), .flush(flush4),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_ctrl(ic4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_ctrl(oc4),
        .count(cnt4)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model, DEPTH=2: a plain FIFO queue
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush2) begin
            m2.delete();
        end else if (m2.size() == 0) begin
            if (iv2) m2.push_back('{d: id2, c: ic2});
        end else if (m2.size() == 2) begin
            if (or2) void'(m2.pop_front());
        end else begin
            if (or2) void'(m2.pop_front());
            if (iv2) m2.push_back('{d: id2, c: ic2});
        end
    end

    // Reference model, DEPTH=4
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush4) begin
            m4.delete();
        end else if (m4.size() == 0) begin
            if (iv4) m4.push_back('{d: id4, c: ic4});
        end else if (m4.size() == 4) begin
            if (or4) void'(m4.pop_front());
        end else begin
            if (or4) void'(m4.pop_front());
            if (iv4) m4.push_back('{d: id4, c: ic4});
        end
    end

    // Per-cycle comparison against the models, away from the active edge
    always @(negedge clk) begin
        chk("u2.count",     128'(cnt2), 128'(m2.size()));
        chk("u2.in_ready",  128'(ir2),  128'(m2.size() != 2));
        chk("u2.out_valid", 128'(ov2),  128'(m2.size() != 0));
        chk("u2.out_data",  128'(od2),  (m2.size() != 0) ? 128'(m2[0].d) : 128'(0));
        chk("u2.out_ctrl",  128'(oc2),  (m2.size() != 0) ? 128'(m2[0].c) : 128'(0));
        chk("u4.count",     128'(cnt4), 128'(m4.size()));
        chk("u4.in_ready",  128'(ir4),  128'(m4.size() != 4));
        chk("u4.out_valid", 128'(ov4),  128'(m4.size() != 0));
        chk("u4.out_data",  128'(od4),  (m4.size() != 0) ? 128'(m4[0].d) : 128'(0));
        chk("u4.out_ctrl",  128'(oc4),  (m4.size() != 0) ? 128'(m4[0].c) : 128'(0));
    end

    // Scoreboard capture of what the DEPTH=4 instance actually hands out
    always @(negedge clk) begin
        if (rst_n && !flush4 && ov4 && or4) pops4.push_back(od4);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d4;
        logic acc;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst.count",     128'(cnt2), 0);
        chk("rst.in_ready",  128'(ir2),  1);
        chk("rst.out_valid", 128'(ov2),  0);
        chk("rst.out_data",  128'(od2),  0);

        // Single pass
        iv2 = 1'b1; id2 = 104'h1234; ic2 = 3'b101; or2 = 1'b0;
        step();
        iv2 = 1'b0; id2 = '0; ic2 = '0;
        chk("single.out_valid", 128'(ov2),  1);
        chk("single.out_data",  128'(od2),  128'h1234);
        chk("single.out_ctrl",  128'(oc2),  5);
        chk("single.count",     128'(cnt2), 1);
        or2 = 1'b1;
        step();
        or2 = 1'b0;
        chk("single.drained", 128'(ov2), 0);

        // Fill / full: A, B, C back to back, C refused
        iv2 = 1'b1; id2 = 104'hA; ic2 = 3'd1;
        step();
        id2 = 104'hB; ic2 = 3'd2;
        step();
        id2 = 104'hC; ic2 = 3'd3;
        step();
        iv2 = 1'b0; id2 = '0; ic2 = '0;
        chk("full.count",    128'(cnt2), 2);
        chk("full.in_ready", 128'(ir2),  0);
        chk("full.head",     128'(od2),  128'hA);
        or2 = 1'b1;
        step();
        chk("drain.second",  128'(od2),  128'hB);
        chk("drain.ctrl",    128'(oc2),  2);
        step();
        or2 = 1'b0;
        chk("drain.bubble_v", 128'(ov2), 0);
        chk("drain.bubble_d", 128'(od2), 0);
        chk("drain.bubble_c", 128'(oc2), 0);

        // Streaming 0..9 with both sides always ready
        for (int k = 0; k < 10; k++) begin
            iv2 = 1'b1; or2 = 1'b1; id2 = 104'(k); ic2 = 3'(k);
            step();
            chk("stream.data",  128'(od2),  128'(k));
            chk("stream.count", 128'(cnt2), 1);
            chk("stream.valid", 128'(ov2),  1);
        end
        iv2 = 1'b0; id2 = '0; ic2 = '0;
        step();
        or2 = 1'b0;
        chk("stream.empty", 128'(ov2), 0);

        // Flush colliding with push and pop
        iv2 = 1'b1; id2 = 104'h77; ic2 = 3'd7;
        step();
        chk("flush.pre_count", 128'(cnt2), 1);
        id2 = 104'h88; ic2 = 3'd6; or2 = 1'b1; flush2 = 1'b1;
        step();
        iv2 = 1'b0; or2 = 1'b0; flush2 = 1'b0; id2 = '0; ic2 = '0;
        chk("flush.count", 128'(cnt2), 0);
        chk("flush.valid", 128'(ov2),  0);
        step();
        chk("flush.no_ghost_v", 128'(ov2), 0);
        chk("flush.no_ghost_d", 128'(od2), 0);

        // Reset mid-stream with two entries held
        iv2 = 1'b1; id2 = 104'h11; ic2 = 3'd1;
        step();
        id2 = 104'h22;
        step();
        iv2 = 1'b0; id2 = '0; ic2 = '0;
        chk("midrst.pre_count", 128'(cnt2), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.count",    128'(cnt2), 0);
        chk("midrst.valid",    128'(ov2),  0);
        chk("midrst.data",     128'(od2),  0);
        chk("midrst.in_ready", 128'(ir2),  1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        iv2 = 1'b1; id2 = 104'h33; ic2 = 3'd4;
        step();
        iv2 = 1'b0; id2 = '0; ic2 = '0;
        chk("postrst.count", 128'(cnt2), 1);
        chk("postrst.data",  128'(od2),  128'h33);
        or2 = 1'b1;
        step();
        or2 = 1'b0;

        // Wrap on DEPTH=4 with random downstream backpressure
        pops4.delete();
        d4 = 0;
        for (int i = 0; i < 24; i++) begin
            iv4 = 1'b1; id4 = 104'(d4); ic4 = 3'(d4);
            or4 = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ir4;
            step();
            if (acc) d4++;
        end
        iv4 = 1'b0; id4 = '0; ic4 = '0; or4 = 1'b1;
        repeat (6) step();
        or4 = 1'b0;
        chk("wrap.empty",      128'(cnt4), 0);
        chk("wrap.pop_total",  128'(pops4.size()), 128'(d4));
        for (int i = 0; i < pops4.size(); i++) begin
            chk("wrap.order", 128'(pops4[i]), 128'(i));
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
